fp_mult_arbiter: RTL and testbench
==================================

Name: fp_mult_arbiter

Overview:
- Shares one single-precision FP multiplier (fp_mult: inputs registered on clk, product combinational from the registered operands, latency 1) between NUM_REQ requesters.
- Each requester has a valid/ready request port and a valid/ready response port. Round-robin arbitration with at most one operation outstanding per requester.
- Sits between issuing units (scalar FPU pipe, vector lane sequencer) and the shared multiplier.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
FP_W, 32, operand/result width
MUL_LAT, 1, cycles from operands driven on mul_a/mul_b to a valid mul_res

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_a  in  NUM_REQ*FP_W  operand A, requester i at [i*FP_W +: FP_W]
req_b  in  NUM_REQ*FP_W  operand B, same packing
req_ready  out  NUM_REQ  request accepted this cycle (one-hot or zero)
resp_valid  out  NUM_REQ  result buffer i holds a result
resp_data  out  NUM_REQ*FP_W  per-requester result buffer
resp_ready  in  NUM_REQ  requester consumes result
mul_a  out  FP_W  to multiplier operand A
mul_b  out  FP_W  to multiplier operand B
mul_res  in  FP_W  from multiplier result

Behaviour:
- Reset (async assert, sync release): rr_ptr=0, all busy=0, tag pipe cleared, resp_valid=0, resp_data=0. req_ready and mul_a/mul_b are combinational and read 0 while in reset.
- Eligibility: elig[i] = req_valid[i] & ~busy[i]. busy[i] is set on the grant edge and cleared on the edge where resp_valid[i] & resp_ready[i].
- Arbitration, combinational in cycle T:
  - grant = first set bit of elig, searching from rr_ptr upward with wrap.
  - req_ready = grant (one-hot); at most one grant per cycle.
  - mul_a/mul_b = granted requester's operands; all-zero when no grant.
- rr_ptr update: on a grant to g, rr_ptr <= (g+1) mod NUM_REQ; otherwise unchanged.
- Tag pipe: shift register of depth MUL_LAT, each stage {vld, id[$clog2(NUM_REQ)-1:0]}. Stage 0 is loaded with {grant!=0, grant index}.
- Capture: when the last stage vld=1, the edge at end of cycle T+MUL_LAT writes resp_data[id] <= mul_res and sets resp_valid[id]=1.
- Latency: resp_valid rises in cycle T+MUL_LAT+1 (T+2 for default). Throughput is one op/cycle across distinct requesters.
- Response handshake: resp_valid[i] & resp_ready[i] clears resp_valid[i] and busy[i] on that edge. resp_data holds its value until overwritten.
- Same-requester back-to-back: blocked by busy until its response is consumed. A new request from i may be granted in the same cycle resp_ready[i] fires? No: busy is cleared at that edge, so the earliest re-grant is the next cycle.
- Capture never collides with an occupied buffer, by construction (busy spans issue through consume). Assert (simulation-only) capture-into-valid-buffer never occurs.
- Requester drops req_valid without req_ready: legal, nothing issued.
- Operands need only be stable in the grant cycle.
- Reset mid-flight: all in-flight tags and buffered results are discarded. No response is produced for them.
- No stall input to the multiplier. The result must be captured exactly MUL_LAT cycles after issue.

Decomposition:
- fpu_pkg: FP_W, FP_MUL_LAT, and the typedef of the tag-pipe entry {vld, id}.
- Sub-module rr_arbiter (NUM_REQ): inputs req vector, ptr; output one-hot grant. Pure combinational, reused by the FP add/div sharers.

Test Plan:
- Single op: req0 a=0x40400000 b=0x40000000 in cycle 0 -> req_ready[0]=1 cycle 0, mul_a=0x40400000; resp_valid[0]=1 at cycle 2 with resp_data[0]=0x40C00000.
- Contention: req0 and req1 both valid cycle 0 (ptr=0). Ops 0xBF800000*0x40000000 and 0x3F800000*0x3F800000 -> grant0 cycle 0, grant1 cycle 1. resp0=0xC0000000 at cycle 2, resp1=0x3F800000 at cycle 3. Ptr ends at 0.
- Backpressure: resp_ready[0]=0 for 5 cycles with req0 still valid -> req_ready[0] stays 0. req1 is still granted every time eligible. After resp_ready[0] pulse, req0 is granted the next cycle.
- Zero operand: a=0x00000000 b=0x3F800000 -> resp_data=0x00000000. a=0x80000000 b=0x40000000 -> 0x00000000.
- Reset mid-flight: grant req1 cycle 0, assert rst_n=0 cycle 1 -> resp_valid stays 0, busy cleared. After release, req1 is granted immediately and answers normally.
- Fairness soak: all NUM_REQ always valid with resp_ready=1 for 200 cycles -> grant counts per requester differ by ≤1. No capture-collision assertion fires.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared constants and tag-pipe entry type for the FP unit sharers.
package fpu_pkg;

  localparam int unsigned FP_W       = 32;
  localparam int unsigned FP_MUL_LAT = 1;
  // Wide enough for the largest supported requester count (8).
  localparam int unsigned TAG_ID_W   = 3;

  typedef struct packed {
    logic                vld;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/fp_mult_arbiter_if.sv
// Requester-side and multiplier-side signals of the shared FP multiplier arbiter.
interface fp_mult_arbiter_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned FP_W    = fpu_pkg::FP_W
);

  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ*FP_W-1:0] req_a;
  logic [NUM_REQ*FP_W-1:0] req_b;
  logic [NUM_REQ-1:0]      resp_valid;
  logic [NUM_REQ-1:0]      resp_ready;
  logic [NUM_REQ*FP_W-1:0] resp_data;
  logic [FP_W-1:0]         mul_a;
  logic [FP_W-1:0]         mul_b;
  logic [FP_W-1:0]         mul_res;

  // Arbiter view.
  modport slave (
    input  req_valid, req_a, req_b, resp_ready, mul_res,
    output req_ready, resp_valid, resp_data, mul_a, mul_b
  );

  // Requester/multiplier view.
  modport master (
    output req_valid, req_a, req_b, resp_ready, mul_res,
    input  req_ready, resp_valid, resp_data, mul_a, mul_b
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: lowest requesting index at or above ptr_i, else wrap.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned PtrW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PtrW-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] grant_o
);

  logic [NUM_REQ-1:0] upper_mask;
  logic [NUM_REQ-1:0] req_upper;
  logic [NUM_REQ-1:0] pick;

  assign upper_mask = ~((NUM_REQ'(1) << ptr_i) - NUM_REQ'(1));
  assign req_upper  = req_i & upper_mask;
  assign pick       = (|req_upper) ? req_upper : req_i;
  // Isolate the lowest set bit.
  assign grant_o    = pick & (~pick + NUM_REQ'(1));

endmodule

// File: rtl/fp_mult_arbiter.sv
// Shares one fixed-latency FP multiplier between NUM_REQ requesters, round-robin,
// with a per-requester result buffer and at most one outstanding op per requester.
module fp_mult_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned FP_W    = fpu_pkg::FP_W,
  parameter int unsigned MUL_LAT = fpu_pkg::FP_MUL_LAT
) (
  input logic              clk,
  input logic              rst_n,
  fp_mult_arbiter_if.slave bus
);

  import fpu_pkg::*;

  localparam int unsigned IdW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]           elig;
  logic [NUM_REQ-1:0]           grant_raw;
  logic [NUM_REQ-1:0]           grant;
  logic [NUM_REQ-1:0]           consume;
  logic [NUM_REQ-1:0]           cap_oh;
  logic [NUM_REQ-1:0]           busy_q, busy_d;
  logic [NUM_REQ-1:0]           resp_valid_q, resp_valid_d;
  logic [NUM_REQ-1:0][FP_W-1:0] resp_data_q, resp_data_d;
  logic [IdW-1:0]               rr_ptr_q, rr_ptr_d;
  logic [IdW-1:0]               grant_idx;
  tag_t [MUL_LAT-1:0]           tag_q, tag_d;
  tag_t                         cap;

  assign elig = bus.req_valid & ~busy_q;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_arbiter (
    .req_i  (elig),
    .ptr_i  (rr_ptr_q),
    .grant_o(grant_raw)
  );

  // Nothing is issued while reset is held.
  assign grant = rst_n ? grant_raw : '0;

  always_comb begin : grant_decode
    grant_idx = '0;
    bus.mul_a = '0;
    bus.mul_b = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        grant_idx = IdW'(i);
        bus.mul_a = bus.req_a[i*FP_W +: FP_W];
        bus.mul_b = bus.req_b[i*FP_W +: FP_W];
      end
    end
  end

  always_comb begin : tag_pipe
    tag_d        = tag_q;
    tag_d[0].vld = |grant;
    tag_d[0].id  = TAG_ID_W'(grant_idx);
    for (int unsigned s = 1; s < MUL_LAT; s++) begin
      tag_d[s] = tag_q[s-1];
    end
  end

  assign cap     = tag_q[MUL_LAT-1];
  assign consume = resp_valid_q & bus.resp_ready;

  always_comb begin : capture_decode
    cap_oh = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cap_oh[i] = cap.vld && (cap.id == TAG_ID_W'(i));
    end
  end

  always_comb begin : resp_next
    resp_valid_d = resp_valid_q & ~consume;
    resp_data_d  = resp_data_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (cap_oh[i]) begin
        resp_valid_d[i] = 1'b1;
        resp_data_d[i]  = bus.mul_res;
      end
    end
  end

  // busy spans grant through consume, so a capture never lands on a full buffer.
  assign busy_d = (busy_q | grant) & ~consume;

  always_comb begin : ptr_next
    rr_ptr_d = rr_ptr_q;
    if (|grant) begin
      rr_ptr_d = (grant_idx == IdW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q     <= '0;
      busy_q       <= '0;
      tag_q        <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      busy_q       <= busy_d;
      tag_q        <= tag_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign bus.req_ready  = grant;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;

  capture_no_collision_a : assert property (
    @(posedge clk) disable iff (!rst_n) !(|(cap_oh & resp_valid_q))
  );

endmodule

// File: tb/tb_fp_mult_arbiter.sv
// Bench for fp_mult_arbiter: behavioural multiplier stub plus a transaction-level reference model.
module tb_fp_mult_arbiter;

  localparam int unsigned N   = 2;
  localparam int unsigned W   = 32;
  localparam int unsigned LAT = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  fp_mult_arbiter_if #(.NUM_REQ(N), .FP_W(W)) bus ();

  fp_mult_arbiter #(
    .NUM_REQ(N),
    .FP_W   (W),
    .MUL_LAT(LAT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Simplified FP32 multiply: zero/denormal inputs give +0, truncating, overflow to inf.
  function automatic logic [31:0] fp_mul(input logic [31:0] x, input logic [31:0] y);
    logic [47:0] p;
    logic [22:0] m;
    int          e;
    if (x[30:23] == 8'h0 || y[30:23] == 8'h0) return 32'h0;
    p = {24'h0, 1'b1, x[22:0]} * {24'h0, 1'b1, y[22:0]};
    e = int'(x[30:23]) + int'(y[30:23]) - 127;
    if (p[47]) begin
      m = p[46:24];
      e++;
    end else begin
      m = p[45:23];
    end
    if (e >= 255) return {x[31] ^ y[31], 8'hFF, 23'h0};
    if (e <= 0) return 32'h0;
    return {x[31] ^ y[31], e[7:0], m};
  endfunction

  // Multiplier: operands registered, product combinational from the registers.
  logic [W-1:0] ma_q, mb_q;
  always @(posedge clk) begin
    ma_q <= bus.mul_a;
    mb_q <= bus.mul_b;
  end
  assign bus.mul_res = fp_mul(ma_q, mb_q);

  // Stimulus state.
  bit          drv_rst = 1'b1;
  bit          drv_v  [N];
  logic [31:0] drv_a  [N];
  logic [31:0] drv_b  [N];
  bit          drv_rr [N];

  // Reference model.
  int          m_ptr;
  bit          m_busy [N];
  int          m_cnt  [N];
  logic [31:0] m_pend [N];
  bit          m_rv   [N];
  logic [31:0] m_rd   [N];
  int          dut_gcount [N];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_ptr = 0;
    for (int i = 0; i < N; i++) begin
      m_busy[i] = 1'b0;
      m_cnt[i]  = 0;
      m_pend[i] = '0;
      m_rv[i]   = 1'b0;
      m_rd[i]   = '0;
    end
  endfunction

  function automatic int model_grant();
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (drv_v[idx] && !m_busy[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic void model_edge(input int g);
    for (int i = 0; i < N; i++) begin
      if (m_rv[i] && drv_rr[i]) begin
        m_rv[i]   = 1'b0;
        m_busy[i] = 1'b0;
      end
      if (m_cnt[i] > 0) begin
        m_cnt[i]--;
        if (m_cnt[i] == 0) begin
          m_rv[i] = 1'b1;
          m_rd[i] = m_pend[i];
        end
      end
    end
    if (g >= 0) begin
      m_busy[g] = 1'b1;
      m_cnt[g]  = LAT;
      m_pend[g] = fp_mul(drv_a[g], drv_b[g]);
      m_ptr     = (g + 1) % N;
    end
  endfunction

  // One clock cycle: drive at negedge, compare 1 time unit later, advance the model.
  task automatic step();
    int           g;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    rst_n = drv_rst;
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i]        = drv_v[i];
      bus.req_a[i*W +: W]     = drv_a[i];
      bus.req_b[i*W +: W]     = drv_b[i];
      bus.resp_ready[i]       = drv_rr[i];
    end
    #1;
    if (!rst_n) model_reset();
    g = rst_n ? model_grant() : -1;
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
    check("mul_a", 64'(bus.mul_a), (g >= 0) ? 64'(drv_a[g]) : 64'h0);
    check("mul_b", 64'(bus.mul_b), (g >= 0) ? 64'(drv_b[g]) : 64'h0);
    for (int i = 0; i < N; i++) begin
      check($sformatf("resp_valid%0d", i), 64'(bus.resp_valid[i]), 64'(m_rv[i]));
      check($sformatf("resp_data%0d", i), 64'(bus.resp_data[i*W +: W]), 64'(m_rd[i]));
      if (bus.req_ready[i]) dut_gcount[i]++;
    end
    if (rst_n) model_edge(g);
  endtask

  function automatic logic [31:0] rand_fp();
    if ($urandom_range(0, 7) == 0) return 32'h0;
    return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom)};
  endfunction

  task automatic idle_all();
    for (int i = 0; i < N; i++) begin
      drv_v[i]  = 1'b0;
      drv_rr[i] = 1'b0;
      drv_a[i]  = '0;
      drv_b[i]  = '0;
    end
  endtask

  task automatic pulse_reset();
    drv_rst = 1'b0;
    step();
    drv_rst = 1'b1;
  endtask

  initial begin
    int mn, mx, tot;
    bus.req_valid  = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = '0;
    model_reset();
    idle_all();
    #1 rst_n = 1'b0;
    drv_rst = 1'b0;
    step();
    check("rst_resp_valid", 64'(bus.resp_valid), 64'h0);
    step();
    drv_rst = 1'b1;

    // Single op.
    drv_v[0] = 1'b1; drv_a[0] = 32'h40400000; drv_b[0] = 32'h40000000;
    step();
    check("single_rdy", 64'(bus.req_ready), 64'h1);
    check("single_mul_a", 64'(bus.mul_a), 64'h40400000);
    drv_v[0] = 1'b0;
    step();
    step();
    check("single_rv", 64'(bus.resp_valid[0]), 64'h1);
    check("single_res", 64'(bus.resp_data[31:0]), 64'h40C00000);
    drv_rr[0] = 1'b1;
    step();
    drv_rr[0] = 1'b0;

    // Contention from ptr=0.
    pulse_reset();
    drv_v[0] = 1'b1; drv_a[0] = 32'hBF800000; drv_b[0] = 32'h40000000;
    drv_v[1] = 1'b1; drv_a[1] = 32'h3F800000; drv_b[1] = 32'h3F800000;
    step();
    check("cont_grant0", 64'(bus.req_ready), 64'h1);
    step();
    check("cont_grant1", 64'(bus.req_ready), 64'h2);
    drv_v[0] = 1'b0; drv_v[1] = 1'b0;
    step();
    check("cont_res0", 64'(bus.resp_data[31:0]), 64'hC0000000);
    step();
    check("cont_rv1", 64'(bus.resp_valid[1]), 64'h1);
    check("cont_res1", 64'(bus.resp_data[63:32]), 64'h3F800000);
    drv_rr[0] = 1'b1; drv_rr[1] = 1'b1;
    step();
    drv_rr[0] = 1'b0; drv_rr[1] = 1'b0;
    drv_v[0] = 1'b1; drv_v[1] = 1'b1;
    step();
    check("cont_ptr_wrap", 64'(bus.req_ready), 64'h1);
    step();
    drv_v[0] = 1'b0; drv_v[1] = 1'b0;
    step();
    step();
    drv_rr[0] = 1'b1; drv_rr[1] = 1'b1;
    step();

    // Backpressure on requester 0.
    drv_v[0] = 1'b1; drv_v[1] = 1'b1; drv_rr[0] = 1'b0; drv_rr[1] = 1'b1;
    step();
    for (int c = 0; c < 7; c++) begin
      drv_a[1] = rand_fp(); drv_b[1] = rand_fp();
      step();
      check("bp_rdy0_low", 64'(bus.req_ready[0]), 64'h0);
    end
    drv_v[1] = 1'b0; drv_rr[0] = 1'b1;
    step();
    drv_rr[0] = 1'b0;
    step();
    check("bp_regrant0", 64'(bus.req_ready[0]), 64'h1);
    drv_v[0] = 1'b0; drv_rr[0] = 1'b1; drv_rr[1] = 1'b1;
    repeat (4) step();
    idle_all();

    // Zero operands.
    drv_v[0] = 1'b1; drv_a[0] = 32'h00000000; drv_b[0] = 32'h3F800000;
    step();
    drv_v[0] = 1'b0;
    step();
    step();
    check("zero_pos", 64'(bus.resp_data[31:0]), 64'h0);
    drv_rr[0] = 1'b1;
    step();
    drv_rr[0] = 1'b0;
    drv_v[0] = 1'b1; drv_a[0] = 32'h80000000; drv_b[0] = 32'h40000000;
    step();
    drv_v[0] = 1'b0;
    step();
    step();
    check("zero_neg", 64'(bus.resp_data[31:0]), 64'h0);
    drv_rr[0] = 1'b1;
    step();
    idle_all();

    // Reset with an op in flight.
    drv_v[1] = 1'b1; drv_a[1] = 32'h40400000; drv_b[1] = 32'h40400000;
    step();
    check("rmf_grant1", 64'(bus.req_ready), 64'h2);
    drv_v[1] = 1'b0; drv_rst = 1'b0;
    step();
    step();
    check("rmf_rv_low", 64'(bus.resp_valid), 64'h0);
    drv_rst = 1'b1; drv_v[1] = 1'b1;
    step();
    check("rmf_regrant1", 64'(bus.req_ready), 64'h2);
    drv_v[1] = 1'b0;
    step();
    step();
    check("rmf_rv1", 64'(bus.resp_valid[1]), 64'h1);
    check("rmf_res1", 64'(bus.resp_data[63:32]), 64'h41100000);
    drv_rr[1] = 1'b1;
    step();
    idle_all();

    // Fairness soak.
    pulse_reset();
    for (int i = 0; i < N; i++) dut_gcount[i] = 0;
    for (int c = 0; c < 200; c++) begin
      for (int i = 0; i < N; i++) begin
        drv_v[i] = 1'b1; drv_rr[i] = 1'b1;
        drv_a[i] = rand_fp(); drv_b[i] = rand_fp();
      end
      step();
    end
    mn = dut_gcount[0]; mx = dut_gcount[0]; tot = 0;
    for (int i = 0; i < N; i++) begin
      if (dut_gcount[i] < mn) mn = dut_gcount[i];
      if (dut_gcount[i] > mx) mx = dut_gcount[i];
      tot += dut_gcount[i];
    end
    check("soak_spread_le1", 64'(mx - mn <= 1), 64'h1);
    check("soak_total_ge120", 64'(tot >= 120), 64'h1);

    // Random traffic with occasional reset pulses.
    for (int c = 0; c < 400; c++) begin
      drv_rst = ($urandom_range(0, 99) != 0);
      for (int i = 0; i < N; i++) begin
        drv_v[i]  = ($urandom_range(0, 2) != 0);
        drv_rr[i] = ($urandom_range(0, 3) != 0);
        drv_a[i]  = rand_fp();
        drv_b[i]  = rand_fp();
      end
      step();
    end
    drv_rst = 1'b1;
    idle_all();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
